// File: rtl/pmem_line_responder_if.sv
// 256-bit physical-memory line bus between the cache hierarchy (master)
// and the backing-store responder (slave).
interface pmem_line_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/pmem_line_responder.sv
// Line-granular backing store: accepts one read/write at a time and answers
// with a single-cycle pmem_resp a fixed number of cycles after acceptance.
module pmem_line_responder #(
    parameter int s_lines = 6,
    parameter int latency = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pmem_line_responder_if.slave bus,
    output logic                 pmem_error,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [7:0] LAT_M1 = 8'(latency - 1);

    logic [1:0]         state;
    logic [7:0]         cnt;
    logic               op_wr;
    logic [s_lines-1:0] idx_q;
    logic [255:0]       wd_q;
    logic [255:0]       rdata_q;
    logic [255:0]       mem [0:(1<<s_lines)-1];

    logic               req, accept, enter_resp, eff_wr;
    logic [s_lines-1:0] addr_idx, eff_idx;
    logic [255:0]       eff_wdata;
    logic               unused_addr;

    assign addr_idx    = bus.pmem_address[5+s_lines-1:5];
    assign unused_addr = ^{bus.pmem_address[31:5+s_lines], bus.pmem_address[4:0]};
    assign req         = bus.pmem_read | bus.pmem_write;
    assign accept      = (state == IDLE) && req;

    // With latency 1 the RESP entry edge is the accept edge itself, so the
    // live request fields are used instead of the not-yet-captured copies.
    assign enter_resp = rst_n && ((accept && (latency == 1)) ||
                                  ((state == BUSY) && (cnt == 8'd1)));
    assign eff_wr     = (state == IDLE) ? bus.pmem_write : op_wr;
    assign eff_idx    = (state == IDLE) ? addr_idx       : idx_q;
    assign eff_wdata  = (state == IDLE) ? bus.pmem_wdata : wd_q;

    assign bus.pmem_resp  = (state == RESP);
    assign bus.pmem_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_wr      <= 1'b0;
            idx_q      <= '0;
            wd_q       <= '0;
            rdata_q    <= '0;
            pmem_error <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr <= bus.pmem_write;
                        idx_q <= addr_idx;
                        wd_q  <= bus.pmem_wdata;
                        cnt   <= LAT_M1;
                        if (bus.pmem_read && bus.pmem_write) pmem_error <= 1'b1;
                        state <= (latency == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                    if (op_wr) wr_count <= wr_count + 16'd1;
                    else       rd_count <= rd_count + 16'd1;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp && !eff_wr) rdata_q <= mem[eff_idx];
        end
    end

    // Array is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (enter_resp && eff_wr) mem[eff_idx] <= eff_wdata;
    end
endmodule
